load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store engine between the core's execute stage and a handshaked, word-wide data bus. It replaces the zero-latency byte-array data memory path. Each load or store becomes one bus transaction, and the unit holds the core's PC write via `stall` until the access completes. It also does byte-lane steering, load sign/zero extension, misalignment detection and a bus timeout.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum cycles `mem_valid` is held without `mem_ready` before abort. 0 disables the timeout.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_load` in 1: current instruction is a load.
- `req_store` in 1: current instruction is a store.
- `size` in 2: access size. 00 is byte, 01 is half, 10 is word, 11 is illegal.
- `load_unsigned` in 1: zero-extend the load (lbu/lhu).
- `addr` in 32: byte address (rs1+imm).
- `wdata` in 32: store data (rs2), right-justified.
- `stall` out 1: hold PC and register-file write.
- `done` out 1: one-cycle completion pulse; `rdata` is valid while it is high.
- `rdata` out 32: extended load result. 0 for stores and faults.
- `misaligned` out 1: fault flag, valid with `done`.
- `bus_err` out 1: timeout flag, valid with `done`.
- `mem_valid` out 1: bus request.
- `mem_ready` in 1: bus accept/complete. The transfer happens on the edge where `mem_valid` and `mem_ready` are both high.
- `mem_we` out 1: 1 for a store.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wstrb` out 4: byte enables. 0000 for loads.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: read word, sampled on the handshake edge.

## Operation

States: IDLE, BUS, RESP.
- **IDLE**:
  - A request is `req_load|req_store`. If both are high, the store wins.
  - Misaligned means any of: `size`=11; half with `addr[0]`=1; word with `addr[1:0]`≠0.
  - On a request that is not misaligned: register `mem_addr`, `mem_we`, `mem_wstrb`, `mem_wdata`; set `mem_valid`=1; go to BUS.
  - On a misaligned request: no bus activity; go to RESP with `misaligned`=1 and `rdata`=0.
- **BUS**:
  - Hold `mem_valid` and all `mem_*` outputs constant.
  - The timeout counter increments each cycle without `mem_ready`.
  - On the handshake edge: clear `mem_valid`, capture and extend `mem_rdata` into `rdata` (loads), go to RESP.
  - If the counter reaches `TIMEOUT_CYCLES` first: clear `mem_valid`, set `bus_err`=1 and `rdata`=0, go to RESP.
- **RESP**:
  - `done`=1 for exactly one cycle. `rdata`, `misaligned` and `bus_err` are held for that cycle.
  - Requests are ignored in this state, so the same instruction is never reissued.
  - Next state is IDLE; flags clear on the exit edge.

Store steering, with `o`=`addr[1:0]`:
- Byte: `mem_wdata` = `wdata[7:0]` replicated 4×; `mem_wstrb` = 0001<<o.
- Half: `mem_wdata` = `{2{wdata[15:0]}}`; `mem_wstrb` = 0011<<o.
- Word: `mem_wdata` = `wdata`; `mem_wstrb` = 1111.

Load extraction:
- Byte lane is `mem_rdata[8o+7:8o]`; half lane is `mem_rdata[8o+15:8o]`.
- Sign-extend from the lane MSB unless `load_unsigned`=1.
- Word loads pass through unchanged.

`stall` is combinational: `(state==IDLE & (req_load|req_store)) | state==BUS`. It is 0 in RESP, which is when the core writes back and advances the PC. It is forced to 0 while `rst` is high.

## Timing

- Reset, asynchronous: state IDLE; counter 0. `mem_valid`, `mem_we`, `mem_addr`, `mem_wstrb`, `mem_wdata`, `rdata`, `done`, `misaligned`, `bus_err` all 0.
- A reset mid-transaction drops `mem_valid` immediately. No `done` is produced.
- Normal access, with the request seen in cycle 0:
  - `mem_valid` is high from cycle 1.
  - The handshake occurs in cycle k≥1.
  - `done` is high in cycle k+1.
  - Minimum load/store latency is 3 cycles with zero-wait `mem_ready`.
- Misaligned request: `done`/`misaligned` in cycle 1; `stall` is high in cycle 0 only.
- Timeout with `TIMEOUT_CYCLES`=N: `mem_valid` is high for cycles 1..N. `done`/`bus_err` in cycle N+1. A `mem_ready` arriving in cycle N+1 or later is ignored.
- A `mem_ready` that arrives in the same cycle the counter hits N counts as a successful handshake; the handshake has priority over the timeout.
- `mem_ready` while `mem_valid`=0 is ignored.
- A new request may be accepted in the IDLE cycle immediately after RESP, giving back-to-back accesses every k+2 cycles.

## Test plan

- **lw, zero wait:** `addr`=0x100, `mem_ready`=1 in cycle 1, `mem_rdata`=0xDEADBEEF → `mem_addr`=0x100, `mem_wstrb`=0000, `done` in cycle 2, `rdata`=0xDEADBEEF, `stall` high in cycles 0–1.
- **Byte lanes:**
  - lb at `addr`=0x103 with `mem_rdata`=0x80FF1234 → `rdata`=0xFFFFFF80.
  - lbu at the same address → `rdata`=0x00000080.
  - lh at 0x102 → `rdata`=0xFFFF80FF.
- **Stores:**
  - sb at 0x201 with `wdata`=0xAB → `mem_wdata`=0xABABABAB, `mem_wstrb`=0010, `mem_we`=1.
  - sh at 0x202 with `wdata`=0x1234 → `mem_wdata`=0x12341234, `mem_wstrb`=1100.
- **Wait states:** `mem_ready` delayed to cycle 5 → `mem_valid` and `mem_*` stable for cycles 1–5, `done` in cycle 6; no reissue during RESP even though `req_load` is still high.
- **Faults:**
  - lw at 0x102 → no `mem_valid`, `done` and `misaligned` in cycle 1.
  - `TIMEOUT_CYCLES`=4 with `mem_ready` never asserted → `mem_valid` for cycles 1–4, `bus_err` and `done` in cycle 5, `rdata`=0.
- **Reset mid-BUS:** assert `rst` in cycle 2 of a pending store → `mem_valid` drops asynchronously, all outputs 0, and the first request after reset is accepted normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Multi-cycle load/store engine sitting between the execute stage and a
//   valid/ready word-wide data bus. Each load or store becomes one bus
//   transaction. While the access is in flight, `stall` holds the PC and the
//   register-file write. The unit also handles byte-lane steering, load
//   sign/zero extension, misalignment faults and a bus timeout.
//
// Ports
//   clk, rst         : clock (rising edge), asynchronous active-high reset
//   req_load/store   : request from the current instruction (store wins if both)
//   size             : 00 byte, 01 half, 10 word, 11 illegal
//   load_unsigned    : zero-extend loads (lbu/lhu)
//   addr, wdata      : byte address and right-justified store data
//   stall            : hold PC / writeback (combinational)
//   done             : one-cycle completion pulse
//   rdata            : extended load result (0 for stores and faults)
//   misaligned       : fault flag, valid with done
//   bus_err          : timeout flag, valid with done
//   mem_valid/ready  : bus handshake
//   mem_we           : 1 for a store
//   mem_addr         : word-aligned address
//   mem_wstrb        : byte enables (0000 for loads)
//   mem_wdata        : lane-replicated store data
//   mem_rdata        : read word, sampled on the handshake edge
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  // Counter wide enough to hold TIMEOUT_CYCLES-1.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mem_valid_q, mem_valid_d;
  logic           mem_we_q, mem_we_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [3:0]     mem_wstrb_q, mem_wstrb_d;
  logic [31:0]    mem_wdata_q, mem_wdata_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           done_q, done_d;
  logic           misaligned_q, misaligned_d;
  logic           bus_err_q, bus_err_d;
  // Load shaping info, captured at request time.
  // The core's inputs are not relied upon while the bus is pending.
  logic [1:0]     ld_size_q, ld_size_d;
  logic [1:0]     ld_off_q, ld_off_d;
  logic           ld_uns_q, ld_uns_d;

  logic           req;
  logic           mis;
  logic [3:0]     st_strb;
  logic [31:0]    st_wdata;
  logic [31:0]    rd_shift;
  logic [31:0]    ld_ext;
  logic           timeout_hit;

  assign req = req_load | req_store;

  // Alignment check.
  always_comb begin
    mis = 1'b0;
    case (size)
      2'b01:   mis = addr[0];
      2'b10:   mis = (addr[1:0] != 2'b00);
      2'b11:   mis = 1'b1;
      default: mis = 1'b0;
    endcase
  end

  // Store steering: replicate data into every lane, so only the strobe depends on the offset.
  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = wdata;
    case (size)
      2'b00: begin
        st_strb  = 4'b0001 << addr[1:0];
        st_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_strb  = 4'b0011 << addr[1:0];
        st_wdata = {2{wdata[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = wdata;
      end
    endcase
  end

  // Load extraction: shift the addressed lane down to bit 0, then extend.
  assign rd_shift = mem_rdata >> {ld_off_q, 3'b000};

  always_comb begin
    ld_ext = mem_rdata;
    case (ld_size_q)
      2'b00:   ld_ext = {{24{~ld_uns_q & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_ext = {{16{~ld_uns_q & rd_shift[15]}}, rd_shift[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  // The counter holds the number of BUS cycles already spent without ready.
  // Hitting N-1 here means this is the N-th cycle of mem_valid.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_valid_d  = mem_valid_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    done_d       = done_q;
    misaligned_d = misaligned_q;
    bus_err_d    = bus_err_q;
    ld_size_d    = ld_size_q;
    ld_off_d     = ld_off_q;
    ld_uns_d     = ld_uns_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (mis) begin
            state_d      = S_RESP;
            done_d       = 1'b1;
            misaligned_d = 1'b1;
            bus_err_d    = 1'b0;
            rdata_d      = 32'h0;
          end else begin
            state_d     = S_BUS;
            cnt_d       = '0;
            mem_valid_d = 1'b1;
            mem_we_d    = req_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wstrb_d = req_store ? st_strb : 4'b0000;
            mem_wdata_d = req_store ? st_wdata : 32'h0;
            ld_size_d   = size;
            ld_off_d    = addr[1:0];
            ld_uns_d    = load_unsigned;
          end
        end
      end
      S_BUS: begin
        // A handshake takes priority over a timeout in the same cycle.
        if (mem_ready) begin
          state_d     = S_RESP;
          mem_valid_d = 1'b0;
          done_d      = 1'b1;
          rdata_d     = mem_we_q ? 32'h0 : ld_ext;
        end else if (timeout_hit) begin
          state_d     = S_RESP;
          mem_valid_d = 1'b0;
          done_d      = 1'b1;
          bus_err_d   = 1'b1;
          rdata_d     = 32'h0;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        // Requests are ignored here so the same instruction is not reissued.
        state_d      = S_IDLE;
        done_d       = 1'b0;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        rdata_d      = 32'h0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wstrb_q  <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      rdata_q      <= 32'h0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      ld_size_q    <= 2'b00;
      ld_off_q     <= 2'b00;
      ld_uns_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
      ld_size_q    <= ld_size_d;
      ld_off_q     <= ld_off_d;
      ld_uns_q     <= ld_uns_d;
    end
  end

  // stall is low in RESP: that is the cycle in which the core writes back and advances.
  assign stall = ~rst & (((state_q == S_IDLE) & req) | (state_q == S_BUS));

  assign done       = done_q;
  assign rdata      = rdata_q;
  assign misaligned = misaligned_q;
  assign bus_err    = bus_err_q;
  assign mem_valid  = mem_valid_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed test of load_store_unit. The main instance uses the default
//   timeout. A second instance with TIMEOUT_CYCLES=4 covers the timeout
//   boundaries. Its requests and mem_ready are separate; all other inputs
//   are shared with the main instance.
//   Inputs are driven 1 time unit after the rising edge. Outputs are sampled
//   on the falling edge. "Cycle c" counts from the cycle in which the request
//   is presented.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_load, req_store, load_unsigned, mem_ready;
  logic [1:0]  size;
  logic [31:0] addr, wdata, mem_rdata;
  logic        stall, done, misaligned, bus_err, mem_valid, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        req_load_t, req_store_t, mem_ready_t;
  logic        stall_t, done_t, misaligned_t, bus_err_t, mem_valid_t, mem_we_t;
  logic [31:0] rdata_t, mem_addr_t, mem_wdata_t;
  logic [3:0]  mem_wstrb_t;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_load(req_load), .req_store(req_store),
    .size(size), .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata), .misaligned(misaligned),
    .bus_err(bus_err), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .req_load(req_load_t), .req_store(req_store_t),
    .size(size), .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
    .stall(stall_t), .done(done_t), .rdata(rdata_t), .misaligned(misaligned_t),
    .bus_err(bus_err_t), .mem_valid(mem_valid_t), .mem_ready(mem_ready_t),
    .mem_we(mem_we_t), .mem_addr(mem_addr_t), .mem_wstrb(mem_wstrb_t),
    .mem_wdata(mem_wdata_t), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  // One complete access on the main instance, with the handshake in cycle k.
  // The request stays high through RESP and is dropped one cycle later, so a
  // reissue would show up as mem_valid in cycle k+2.
  task automatic access(input string name, input logic ld, input logic st,
                        input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rw, input int k,
                        input logic [3:0] e_strb, input logic [31:0] e_wdata,
                        input logic [31:0] e_rdata);
    logic [31:0] e_addr;
    e_addr = {a[31:2], 2'b00};
    for (int c = 0; c <= k + 2; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        req_load = ld; req_store = st; size = sz; load_unsigned = uns;
        addr = a; wdata = wd;
      end
      if (c == k + 2) begin
        req_load = 1'b0; req_store = 1'b0;
      end
      mem_ready = (c == k);
      mem_rdata = (c == k) ? rw : ~rw;
      @(negedge clk);
      if (c <= k) begin
        check($sformatf("%s c%0d stall", name, c), stall, 1);
        check($sformatf("%s c%0d done", name, c), done, 0);
        check($sformatf("%s c%0d mem_valid", name, c), mem_valid, (c != 0));
        if (c >= 1) begin
          check($sformatf("%s c%0d mem_addr", name, c), mem_addr, e_addr);
          check($sformatf("%s c%0d mem_wstrb", name, c), mem_wstrb, e_strb);
          check($sformatf("%s c%0d mem_we", name, c), mem_we, st);
          if (st) check($sformatf("%s c%0d mem_wdata", name, c), mem_wdata, e_wdata);
        end
      end else if (c == k + 1) begin
        check($sformatf("%s done", name), done, 1);
        check($sformatf("%s rdata", name), rdata, e_rdata);
        check($sformatf("%s misaligned", name), misaligned, 0);
        check($sformatf("%s bus_err", name), bus_err, 0);
        check($sformatf("%s resp stall", name), stall, 0);
        check($sformatf("%s resp mem_valid", name), mem_valid, 0);
      end else begin
        check($sformatf("%s after done", name), done, 0);
        check($sformatf("%s no reissue", name), mem_valid, 0);
      end
    end
    mem_ready = 1'b0;
    $display("txn %-10s addr=%08h rdata=%08h", name, a, rdata);
  endtask

  // A misaligned request: no bus activity, with done/misaligned in cycle 1.
  task automatic mis_access(input string name, input logic ld, input logic st,
                            input logic [1:0] sz, input logic [31:0] a);
    for (int c = 0; c <= 2; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        req_load = ld; req_store = st; size = sz; addr = a; wdata = 32'h5555_AAAA;
      end
      if (c == 2) begin
        req_load = 1'b0; req_store = 1'b0;
      end
      mem_ready = 1'b1;  // must be ignored: mem_valid never rises
      @(negedge clk);
      check($sformatf("%s c%0d mem_valid", name, c), mem_valid, 0);
      if (c == 0) begin
        check($sformatf("%s c0 stall", name), stall, 1);
        check($sformatf("%s c0 done", name), done, 0);
      end else if (c == 1) begin
        check($sformatf("%s done", name), done, 1);
        check($sformatf("%s misaligned", name), misaligned, 1);
        check($sformatf("%s rdata", name), rdata, 32'h0);
        check($sformatf("%s stall", name), stall, 0);
      end else begin
        check($sformatf("%s flag clear", name), misaligned, 0);
        check($sformatf("%s done clear", name), done, 0);
      end
    end
    mem_ready = 1'b0;
    $display("txn %-10s addr=%08h misaligned", name, a);
  endtask

  initial begin
    rst = 1'b1;
    req_load = 0; req_store = 0; size = 0; load_unsigned = 0;
    addr = 0; wdata = 0; mem_ready = 0; mem_rdata = 0;
    req_load_t = 0; req_store_t = 0; mem_ready_t = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst mem_valid", mem_valid, 0);
    check("rst done", done, 0);
    check("rst rdata", rdata, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wstrb", mem_wstrb, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst flags", {misaligned, bus_err, mem_we, stall}, 0);
    check("rst dut_to valid", mem_valid_t, 0);
    rst = 1'b0;

    //      name        ld st sz  uns addr          wdata         mem_rdata     k  strb     mem_wdata     rdata
    access("lw",        1, 0, 2, 0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1, 4'b0000, 32'h0,        32'hDEAD_BEEF);
    access("lb",        1, 0, 0, 0, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1, 4'b0000, 32'h0,        32'hFFFF_FF80);
    access("lbu",       1, 0, 0, 1, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1, 4'b0000, 32'h0,        32'h0000_0080);
    access("lh",        1, 0, 1, 0, 32'h0000_0102, 32'h0,        32'h80FF_1234, 1, 4'b0000, 32'h0,        32'hFFFF_80FF);
    access("lhu",       1, 0, 1, 1, 32'h0000_0100, 32'h0,        32'h1234_8765, 2, 4'b0000, 32'h0,        32'h0000_8765);
    access("lb+",       1, 0, 0, 0, 32'h0000_0101, 32'h0,        32'h0000_7F00, 1, 4'b0000, 32'h0,        32'h0000_007F);
    access("sb",        0, 1, 0, 0, 32'h0000_0201, 32'h0000_00AB, 32'h1111_1111, 1, 4'b0010, 32'hABAB_ABAB, 32'h0);
    access("sh",        0, 1, 1, 0, 32'h0000_0202, 32'h0000_1234, 32'h1111_1111, 1, 4'b1100, 32'h1234_1234, 32'h0);
    access("sw",        0, 1, 2, 0, 32'h0000_0204, 32'hCAFE_F00D, 32'h1111_1111, 3, 4'b1111, 32'hCAFE_F00D, 32'h0);
    access("ld+st",     1, 1, 0, 0, 32'h0000_0300, 32'h0000_0042, 32'h1111_1111, 1, 4'b0001, 32'h4242_4242, 32'h0);
    access("lw wait5",  1, 0, 2, 0, 32'h0000_0104, 32'h0,        32'h0BAD_F00D, 5, 4'b0000, 32'h0,        32'h0BAD_F00D);

    mis_access("lw@102", 1, 0, 2'b10, 32'h0000_0102);
    mis_access("sh@201", 0, 1, 2'b01, 32'h0000_0201);
    mis_access("size11", 1, 0, 2'b11, 32'h0000_0100);

    // Timeout on the N=4 instance: mem_valid in cycles 1..4, bus_err/done in cycle 5.
    // A late ready in cycle 5 and beyond must be ignored.
    for (int c = 0; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        req_load_t = 1'b1; size = 2'b10; addr = 32'h0000_0400; load_unsigned = 1'b0;
      end
      if (c == 5) req_load_t = 1'b0;
      mem_ready_t = (c >= 5);
      mem_rdata = 32'h1111_1111;
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        check($sformatf("to c%0d mem_valid", c), mem_valid_t, 1);
        check($sformatf("to c%0d done", c), done_t, 0);
      end else if (c == 5) begin
        check("to done", done_t, 1);
        check("to bus_err", bus_err_t, 1);
        check("to rdata", rdata_t, 32'h0);
        check("to mem_valid", mem_valid_t, 0);
      end else if (c == 6) begin
        check("to late ready", mem_valid_t, 0);
        check("to flag clear", bus_err_t, 0);
      end
    end
    mem_ready_t = 1'b0;
    $display("txn timeout    addr=00000400 bus_err");

    // A handshake in cycle N wins over the timeout.
    for (int c = 0; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 0) req_load_t = 1'b1;
      if (c == 5) req_load_t = 1'b0;
      mem_ready_t = (c == 4);
      mem_rdata = 32'h2468_ACE0;
      @(negedge clk);
      if (c == 4) check("hsN c4 mem_valid", mem_valid_t, 1);
      if (c == 5) begin
        check("hsN done", done_t, 1);
        check("hsN bus_err", bus_err_t, 0);
        check("hsN rdata", rdata_t, 32'h2468_ACE0);
      end
    end
    mem_ready_t = 1'b0;
    $display("txn hs@N       addr=00000400 rdata=%08h", rdata_t);

    // Reset during BUS of a pending store.
    @(posedge clk); #1;
    req_store = 1'b1; size = 2'b10; addr = 32'h0000_0300; wdata = 32'h55AA_55AA; mem_ready = 1'b0;
    @(negedge clk);
    check("rstbus c0 stall", stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstbus c1 mem_valid", mem_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstbus mem_valid", mem_valid, 0);
    check("rstbus stall", stall, 0);
    check("rstbus mem_addr", mem_addr, 0);
    check("rstbus mem_wstrb", mem_wstrb, 0);
    check("rstbus mem_wdata", mem_wdata, 0);
    check("rstbus flags", {done, mem_we, misaligned, bus_err}, 0);
    req_store = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstbus no done", done, 0);
    $display("txn reset-bus  addr=00000300");
    access("post-rst",  0, 1, 2, 0, 32'h0000_0308, 32'h0F0F_0F0F, 32'h0,        1, 4'b1111, 32'h0F0F_0F0F, 32'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
